// File: rtl/timer_pkg.sv
// Shared definitions for the countdown clock: mode encoding, per-digit
// wrap limits and the default preset time.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_PAUSE   = 2'd0,
        MODE_SET     = 2'd1,
        MODE_RUN     = 2'd2,
        MODE_EXPIRED = 2'd3
    } mode_t;

    localparam logic [3:0]  SEC_UNITS_MAX     = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX      = 4'd5;
    localparam logic [3:0]  MIN_UNITS_MAX     = 4'd9;
    localparam logic [3:0]  MIN_TENS_MAX      = 4'd9;
    localparam logic [15:0] DEFAULT_INIT_TIME = 16'h0500;

    function automatic logic [3:0] digit_max(input logic [1:0] idx);
        case (idx)
            2'd0:    return SEC_UNITS_MAX;
            2'd1:    return SEC_TENS_MAX;
            2'd2:    return MIN_UNITS_MAX;
            default: return MIN_TENS_MAX;
        endcase
    endfunction

    // Wraps on >= so an out-of-range digit still returns to 0.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD MM:SS value, with a flag
// telling whether the result is 00:00.
module bcd_mmss_dec
    import timer_pkg::*;
(
    input  logic [15:0] time_bcd,
    output logic [15:0] time_dec,
    output logic        zero_next
);

    always_comb begin
        logic borrow;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        borrow   = 1'b1;
        time_dec = time_bcd;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (time_bcd[i*4 +: 4] == 4'd0) begin
                    time_dec[i*4 +: 4] = digit_max(2'(i));
                end else begin
                    time_dec[i*4 +: 4] = time_bcd[i*4 +: 4] - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
        zero_next = (time_dec == 16'h0000);
    end

endmodule

// File: rtl/timer_mode_controller.sv
// Countdown clock sequencer: owns the MM:SS register, the set/run/pause/expired
// state machine driven by button pulses, and the decrement-tick prescaler.
module timer_mode_controller
    import timer_pkg::*;
#(
    parameter int          TICK_DIV  = 100_000_000,
    parameter logic [15:0] INIT_TIME = DEFAULT_INIT_TIME
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_start,
    output logic [1:0]  mode,
    output logic [15:0] time_bcd,
    output logic [1:0]  digit_sel,
    output logic        tick,
    output logic        expired
);

    localparam int                  PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);

    mode_t              state, state_next;
    logic [15:0]        time_next, preset, preset_next, time_dec;
    logic [1:0]         digit_sel_next;
    logic [PRESC_W-1:0] presc, presc_next;
    logic               zero_next;
    logic [3:0]         edit_pos;

    bcd_mmss_dec u_dec (
        .time_bcd  (time_bcd),
        .time_dec  (time_dec),
        .zero_next (zero_next)
    );

    assign tick     = (state == MODE_RUN) && (presc == PRESC_LAST);
    assign mode     = state;
    assign edit_pos = {digit_sel, 2'b00};

    always_comb begin
        state_next     = state;
        time_next      = time_bcd;
        preset_next    = preset;
        digit_sel_next = digit_sel;
        presc_next     = presc;
        case (state)
            MODE_SET: begin
                if (btn_start && (time_bcd != 16'h0000)) begin
                    preset_next = time_bcd;
                    presc_next  = '0;
                    state_next  = MODE_RUN;
                end else begin
                    // Increment uses the pre-advance digit when both buttons coincide.
                    if (btn_inc)
                        time_next[edit_pos +: 4] = digit_inc(time_bcd[edit_pos +: 4], digit_max(digit_sel));
                    if (btn_sel)
                        digit_sel_next = digit_sel + 2'd1;
                end
            end
            MODE_RUN: begin
                if (tick) begin
                    time_next  = time_dec;
                    presc_next = '0;
                    if (zero_next)
                        state_next = MODE_EXPIRED;
                    else if (btn_start)
                        state_next = MODE_PAUSE;
                end else if (btn_start) begin
                    // Prescaler freezes on the pausing edge so resume continues the same count.
                    state_next = MODE_PAUSE;
                end else begin
                    presc_next = presc + PRESC_ONE;
                end
            end
            MODE_PAUSE: begin
                if (btn_start) begin
                    state_next = MODE_RUN;
                end else if (btn_sel) begin
                    state_next     = MODE_SET;
                    digit_sel_next = 2'd0;
                    presc_next     = '0;
                end
            end
            MODE_EXPIRED: begin
                time_next = 16'h0000;
                if (btn_start) begin
                    state_next     = MODE_SET;
                    time_next      = preset;
                    digit_sel_next = 2'd0;
                end
            end
            default: state_next = MODE_SET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= MODE_SET;
            time_bcd  <= INIT_TIME;
            preset    <= INIT_TIME;
            digit_sel <= 2'd0;
            presc     <= '0;
            expired   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= state_next;
            time_bcd  <= time_next;
            preset    <= preset_next;
            digit_sel <= digit_sel_next;
            presc     <= presc_next;
            expired   <= (state_next == MODE_EXPIRED);
        end
    end

endmodule

// File: tb/tb_timer_mode_controller.sv
// Directed bench for timer_mode_controller: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_timer_mode_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_sel = 1'b0, btn_inc = 1'b0, btn_start = 1'b0;
    logic [1:0]  mode, digit_sel;
    logic [15:0] time_bcd;
    logic        tick, expired;

    timer_mode_controller #(.TICK_DIV(4), .INIT_TIME(16'h0500)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .btn_start (btn_start),
        .mode      (mode),
        .time_bcd  (time_bcd),
        .digit_sel (digit_sel),
        .tick      (tick),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [21:0] want;   // {mode, time_bcd, digit_sel, expired, tick}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_now(input string name, input logic [1:0] m, input logic [15:0] t,
                              input logic [1:0] ds, input logic ex, input logic tk);
        sb.push_back('{cyc: cyc, name: name, want: {m, t, ds, ex, tk}});
    endtask

    // Monitor: compares every expectation due in the current cycle.
    exp_t e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if ({mode, time_bcd, digit_sel, expired, tick} !== e.want) begin
                errors++;
                $display("FAIL %s: got mode=%0d time=%h sel=%0d expired=%b tick=%b, want mode=%0d time=%h sel=%0d expired=%b tick=%b",
                         e.name, mode, time_bcd, digit_sel, expired, tick,
                         e.want[21:20], e.want[19:4], e.want[3:2], e.want[1], e.want[0]);
            end
        end
    end

    task automatic step(input logic s, input logic i, input logic st);
        btn_sel = s; btn_inc = i; btn_start = st;
        @(posedge clk); #1;
        btn_sel = 1'b0; btn_inc = 1'b0; btn_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic inc_n(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion within 200000 time units");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        expect_now("reset", 2'd1, 16'h0500, 2'd0, 1'b0, 1'b0);
        idle(2);
        expect_now("set_no_tick", 2'd1, 16'h0500, 2'd0, 1'b0, 1'b0);

        step(1, 0, 0);
        expect_now("sel_adv", 2'd1, 16'h0500, 2'd1, 1'b0, 1'b0);
        inc_n(5);
        expect_now("inc_to_5", 2'd1, 16'h0550, 2'd1, 1'b0, 1'b0);
        inc_n(1);
        expect_now("d1_wrap", 2'd1, 16'h0500, 2'd1, 1'b0, 1'b0);
        step(1, 1, 0);
        expect_now("inc_sel_same", 2'd1, 16'h0510, 2'd2, 1'b0, 1'b0);
        inc_n(6);
        expect_now("d2_wrap", 2'd1, 16'h0110, 2'd2, 1'b0, 1'b0);
        repeat (3) step(1, 0, 0);
        inc_n(5);
        expect_now("preset_0100", 2'd1, 16'h0100, 2'd1, 1'b0, 1'b0);

        step(0, 0, 1);
        expect_now("run_entry", 2'd2, 16'h0100, 2'd1, 1'b0, 1'b0);
        idle(3);
        expect_now("first_tick", 2'd2, 16'h0100, 2'd1, 1'b0, 1'b1);
        idle(1);
        expect_now("dec_0059", 2'd2, 16'h0059, 2'd1, 1'b0, 1'b0);
        idle(3);
        expect_now("second_tick", 2'd2, 16'h0059, 2'd1, 1'b0, 1'b1);
        idle(1);
        expect_now("dec_0058", 2'd2, 16'h0058, 2'd1, 1'b0, 1'b0);
        step(0, 0, 1);
        expect_now("pause", 2'd0, 16'h0058, 2'd1, 1'b0, 1'b0);
        step(1, 0, 0);
        expect_now("pause_to_set", 2'd1, 16'h0058, 2'd0, 1'b0, 1'b0);

        inc_n(4);
        step(1, 0, 0);
        inc_n(1);
        expect_now("preset_0002", 2'd1, 16'h0002, 2'd1, 1'b0, 1'b0);
        step(0, 0, 1);
        expect_now("run_0002", 2'd2, 16'h0002, 2'd1, 1'b0, 1'b0);
        idle(3);
        expect_now("tick_a", 2'd2, 16'h0002, 2'd1, 1'b0, 1'b1);
        idle(1);
        expect_now("dec_0001", 2'd2, 16'h0001, 2'd1, 1'b0, 1'b0);
        idle(3);
        expect_now("tick_b", 2'd2, 16'h0001, 2'd1, 1'b0, 1'b1);
        idle(1);
        expect_now("expired", 2'd3, 16'h0000, 2'd1, 1'b1, 1'b0);
        idle(2);
        expect_now("expired_hold", 2'd3, 16'h0000, 2'd1, 1'b1, 1'b0);
        step(1, 1, 0);
        expect_now("expired_ignore", 2'd3, 16'h0000, 2'd1, 1'b1, 1'b0);
        step(0, 0, 1);
        expect_now("expired_ack", 2'd1, 16'h0002, 2'd0, 1'b0, 1'b0);

        step(1, 0, 0);
        expect_now("sel_before_run", 2'd1, 16'h0002, 2'd1, 1'b0, 1'b0);
        step(0, 0, 1);
        idle(2);
        expect_now("run_presc2", 2'd2, 16'h0002, 2'd1, 1'b0, 1'b0);
        step(0, 0, 1);
        expect_now("pause_mid", 2'd0, 16'h0002, 2'd1, 1'b0, 1'b0);
        idle(10);
        expect_now("pause_hold", 2'd0, 16'h0002, 2'd1, 1'b0, 1'b0);
        step(0, 0, 1);
        expect_now("resume", 2'd2, 16'h0002, 2'd1, 1'b0, 1'b0);
        idle(1);
        expect_now("resume_tick", 2'd2, 16'h0002, 2'd1, 1'b0, 1'b1);
        step(0, 0, 1);
        expect_now("tick_and_pause", 2'd0, 16'h0001, 2'd1, 1'b0, 1'b0);
        step(1, 0, 0);
        expect_now("pause_sel_set", 2'd1, 16'h0001, 2'd0, 1'b0, 1'b0);

        step(0, 0, 1);
        expect_now("run_0001", 2'd2, 16'h0001, 2'd0, 1'b0, 1'b0);
        idle(3);
        expect_now("tick_c", 2'd2, 16'h0001, 2'd0, 1'b0, 1'b1);
        step(0, 0, 1);
        expect_now("expired_wins", 2'd3, 16'h0000, 2'd0, 1'b1, 1'b0);
        step(0, 0, 1);
        expect_now("ack_preset", 2'd1, 16'h0001, 2'd0, 1'b0, 1'b0);

        inc_n(9);
        expect_now("d0_wrap_zero", 2'd1, 16'h0000, 2'd0, 1'b0, 1'b0);
        step(0, 0, 1);
        expect_now("start_zero_ignored", 2'd1, 16'h0000, 2'd0, 1'b0, 1'b0);
        idle(2);
        expect_now("zero_still_set", 2'd1, 16'h0000, 2'd0, 1'b0, 1'b0);

        inc_n(3);
        step(1, 0, 0);
        step(0, 0, 1);
        expect_now("run_0003", 2'd2, 16'h0003, 2'd1, 1'b0, 1'b0);
        idle(1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        expect_now("mid_reset", 2'd1, 16'h0500, 2'd0, 1'b0, 1'b0);
        step(0, 0, 1);
        idle(3);
        expect_now("tick_after_reset", 2'd2, 16'h0500, 2'd0, 1'b0, 1'b1);
        idle(1);
        expect_now("dec_0459", 2'd2, 16'h0459, 2'd0, 1'b0, 1'b0);

        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_mode_controller.md
# timer_mode_controller

Top-level sequencer for the doomsday countdown clock. It owns the 4-digit BCD MM:SS time register, runs the set/run/pause/expired mode state machine from three pre-debounced button pulses, and generates the 1 Hz decrement tick. It drives the display path (`time_bcd`, `digit_sel`) and the alarm path (`expired`).

## Interface

Parameters:
- `TICK_DIV`, 100_000_000: `clk` cycles per decrement tick (1 Hz at 100 MHz). Must be ≥ 2.
- `INIT_TIME`, 16'h0500: reset and default preset value (05:00), in BCD.

Ports:
- `clk`, input, 1: system clock. One clock domain.
- `rst`, input, 1: synchronous, active-low reset.
- `btn_sel`, input, 1: digit-select pulse, one cycle, already debounced.
- `btn_inc`, input, 1: digit-increment pulse, one cycle.
- `btn_start`, input, 1: start/pause/acknowledge pulse, one cycle.
- `mode`, output, 2: current state. 0 = PAUSE, 1 = SET, 2 = RUN, 3 = EXPIRED.
- `time_bcd`, output, 16: [15:12] minutes tens, [11:8] minutes units, [7:4] seconds tens, [3:0] seconds units.
- `digit_sel`, output, 2: digit being edited, 0 = [3:0] … 3 = [15:12].
- `tick`, output, 1: one-cycle decrement strobe, RUN state only.
- `expired`, output, 1: high while in EXPIRED.

## Operation

- Reset (`rst` = 0 at a clock edge):
  - `mode` = SET, `time_bcd` = `preset` = `INIT_TIME`.
  - `digit_sel` = 0, prescaler = 0, `tick` = 0, `expired` = 0.
- SET:
  - `btn_inc` increments the selected digit with no carry into neighbouring digits. Digits 0, 2 and 3 wrap 9→0. Digit 1 wraps 5→0.
  - `btn_sel` advances `digit_sel` modulo 4.
  - If `btn_inc` and `btn_sel` arrive together, the increment applies to the old `digit_sel`, then `digit_sel` advances.
  - `btn_start` with `time_bcd` ≠ 0000: latch `preset` ← `time_bcd`, clear the prescaler, go to RUN.
  - `btn_start` with `time_bcd` = 0000: ignored, stay in SET.
- RUN:
  - The prescaler counts 0..`TICK_DIV`-1.
  - `tick` = 1 when prescaler = `TICK_DIV`-1.
  - On tick, `time_bcd` decrements by one second with BCD borrow: 0→9 on digit 0, 0→5 on digit 1, 0→9 on digit 2, then borrow into digit 3.
  - A decrement that produces 0000 moves the state to EXPIRED.
  - `btn_start` moves the state to PAUSE. `btn_sel` and `btn_inc` are ignored.
- PAUSE:
  - Prescaler and time are held.
  - `btn_start` returns to RUN, and the prescaler resumes from its held value.
  - `btn_sel` returns to SET with `digit_sel` = 0 and the prescaler cleared; `time_bcd` is kept.
  - `btn_inc` is ignored.
- EXPIRED:
  - `time_bcd` = 0000, `expired` = 1.
  - `btn_start` returns to SET with `time_bcd` ← `preset` and `digit_sel` = 0.
  - Other buttons are ignored.
- Simultaneous events:
  - Tick and `btn_start` in the same RUN cycle: the decrement is applied, then the state goes to PAUSE.
  - If that decrement reaches 0000, EXPIRED wins.
  - Reset overrides everything.
- Stored digits outside their legal range are never produced. Any illegal value loaded via `INIT_TIME` is the integrator's error.

## Timing

- All outputs are registered except `tick`, which is combinational from state and prescaler.
- Button effects appear on `mode`, `time_bcd` and `digit_sel` one cycle after the pulse.
- Tick period is exactly `TICK_DIV` cycles of continuous RUN. The first tick comes `TICK_DIV` cycles after the RUN entry edge.
- `time_bcd` shows the decremented value the cycle after `tick`.
- `expired` and `mode` = 3 rise on the same edge that `time_bcd` becomes 0000.
- The prescaler width is $clog2(`TICK_DIV`).

## Structure

- Shared package `timer_pkg` holds:
  - the mode encoding constants: PAUSE = 0, SET = 1, RUN = 2, EXPIRED = 3;
  - the per-digit wrap limits (9, 5, 9, 9);
  - the default `INIT_TIME`.
- Sub-module `bcd_mmss_dec`: combinational. Takes `time_bcd` in and returns the decremented value plus a `zero_next` flag.
- The FSM, prescaler, edit logic and preset register stay in this module.

## Test plan

Use `TICK_DIV` = 4.

1. Reset, then release `rst` → `time_bcd` = 0500, `mode` = 1, `digit_sel` = 0, `expired` = 0, `tick` never asserts in SET.
2. In SET: one `btn_sel`, then five `btn_inc` → 0550. A sixth `btn_inc` → 0500. `btn_sel` and `btn_inc` in the same cycle increments digit 1, then `digit_sel` = 2.
3. Set 0100, `btn_start` → `mode` = 2. `tick` arrives 4 cycles later, and `time_bcd` = 0059 on the next cycle. The next tick gives 0058.
4. Set 0002, start → 0001 after 4 cycles, then 0000 with `mode` = 3 and `expired` = 1. `btn_start` → `mode` = 1, `time_bcd` = 0002.
5. In RUN at prescaler = 2, `btn_start` → PAUSE. Hold 10 cycles: no change. `btn_start` → `tick` 2 cycles later. Pause again, then `btn_sel` → SET with `digit_sel` = 0.
6. In SET with 0000, `btn_start` → stays SET. In RUN mid-count, `rst` low for one edge → all reset values on the next cycle.
